// File: rtl/simon_arbiter.sv
// Two-requester front end for a shared SIMON core, with a one-entry key cache; ack 2 cycles + core latency after grant (key phase skipped on hit).
// Backpressure: requests are held by the requester until its ack; the core paces each phase through ldKey/doneKey and ldData/doneData.
module simon_arbiter #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             R,
    input  logic             req0,
    input  logic             req1,
    input  logic [2*N-1:0]   plain0,
    input  logic [2*N-1:0]   plain1,
    input  logic [M*N-1:0]   key0,
    input  logic [M*N-1:0]   key1,
    output logic             ack0,
    output logic             ack1,
    output logic [2*N-1:0]   cipher0,
    output logic [2*N-1:0]   cipher1,
    output logic             newKey,
    output logic             newData,
    output logic [M*N-1:0]   key,
    output logic [2*N-1:0]   plain,
    input  logic             ldKey,
    input  logic             ldData,
    input  logic             doneKey,
    input  logic             doneData,
    input  logic [2*N-1:0]   cipher
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] KEY_REQ   = 3'd1;
    localparam logic [2:0] KEY_WAIT  = 3'd2;
    localparam logic [2:0] DATA_REQ  = 3'd3;
    localparam logic [2:0] DATA_WAIT = 3'd4;
    localparam logic [2:0] RESP      = 3'd5;

    logic [2:0]     state;
    logic           g;
    logic           p;
    logic           kValid;
    logic [M*N-1:0] lastKey;

    logic           gnt;
    logic           hit;
    logic           key_done;
    logic           data_done;
    logic [M*N-1:0] key_g;
    logic [M*N-1:0] key_c;
    logic [2*N-1:0] plain_g;

    // Both asking: serve whoever was not served last; otherwise the lone requester.
    assign gnt     = (req0 && req1) ? ~p : req1;
    assign key_c   = gnt ? key1 : key0;
    assign hit     = kValid && (lastKey == key_c);

    assign key_g   = g ? key1 : key0;
    assign plain_g = g ? plain1 : plain0;

    // A load and its completion in the same cycle collapse the wait state.
    assign key_done  = ((state == KEY_REQ) && ldKey && doneKey) ||
                       ((state == KEY_WAIT) && doneKey);
    assign data_done = ((state == DATA_REQ) && ldData && doneData) ||
                       ((state == DATA_WAIT) && doneData);

    assign newKey  = (state == KEY_REQ);
    assign newData = (state == DATA_REQ);
    assign key     = ((state == KEY_REQ) || (state == KEY_WAIT)) ? key_g : '0;
    assign plain   = ((state == DATA_REQ) || (state == DATA_WAIT)) ? plain_g : '0;
    assign ack0    = (state == RESP) && !g;
    assign ack1    = (state == RESP) && g;

    always_ff @(posedge clk) begin
        if (R) begin
            state <= IDLE;
            g     <= 1'b0;
            p     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        g     <= gnt;
                        state <= hit ? DATA_REQ : KEY_REQ;
                    end
                end
                KEY_REQ: begin
                    if (key_done)
                        state <= DATA_REQ;
                    else if (ldKey)
                        state <= KEY_WAIT;
                end
                KEY_WAIT: begin
                    if (key_done)
                        state <= DATA_REQ;
                end
                DATA_REQ: begin
                    if (data_done)
                        state <= RESP;
                    else if (ldData)
                        state <= DATA_WAIT;
                end
                DATA_WAIT: begin
                    if (data_done)
                        state <= RESP;
                end
                RESP: begin
                    p     <= g;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            kValid  <= 1'b0;
            lastKey <= '0;
            cipher0 <= '0;
            cipher1 <= '0;
        end else begin
            if (key_done) begin
                kValid  <= 1'b1;
                lastKey <= key_g;
            end
            if (data_done) begin
                if (g)
                    cipher1 <= cipher;
                else
                    cipher0 <= cipher;
            end
        end
    end

endmodule

// File: tb/tb_simon_arbiter.sv
// Directed bench for simon_arbiter: behavioural core responder, auto requesters, linear test sequence.
module tb_simon_arbiter;

    localparam logic [63:0] K0 = 64'h1918111009080100;
    localparam logic [63:0] K1 = 64'h0123456789abcdef;
    localparam logic [31:0] P0 = 32'h65656877;
    localparam logic [31:0] P1 = 32'h1234abcd;
    localparam logic [31:0] C0 = 32'hc69be9bb;
    localparam logic [31:0] C1 = 32'h9abc2345;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] plain0 = '0, plain1 = '0;
    logic [63:0] key0 = '0, key1 = '0;
    logic        ack0, ack1, newKey, newData;
    logic [31:0] cipher0, cipher1, plain;
    logic [63:0] key;
    logic        ldKey = 1'b0, ldData = 1'b0, doneKey = 1'b0, doneData = 1'b0;
    logic [31:0] cipher = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    simon_arbiter dut (
        .clk(clk), .R(R),
        .req0(req0), .req1(req1),
        .plain0(plain0), .plain1(plain1),
        .key0(key0), .key1(key1),
        .ack0(ack0), .ack1(ack1),
        .cipher0(cipher0), .cipher1(cipher1),
        .newKey(newKey), .newData(newData),
        .key(key), .plain(plain),
        .ldKey(ldKey), .ldData(ldData),
        .doneKey(doneKey), .doneData(doneData),
        .cipher(cipher)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requesters: raise req when more services are asked for than served, drop it on ack.
    int   ask0 = 0, ask1 = 0, served0 = 0, served1 = 0;
    int   cyc = 0, t0_0 = 0, t0_1 = 0, lat0 = 0, lat1 = 0;
    int   nk = 0, nd = 0;
    logic nk_prev = 1'b0, nd_prev = 1'b0;
    int   ack_q[$];

    always @(negedge clk) begin
        cyc++;
        if (newKey && !nk_prev) nk++;
        if (newData && !nd_prev) nd++;
        nk_prev = newKey;
        nd_prev = newData;
        if (ack0) begin
            ack_q.push_back(0);
            served0++;
            lat0 = cyc - t0_0;
            req0 = 1'b0;
        end else if (!req0 && served0 < ask0) begin
            req0 = 1'b1;
            t0_0 = cyc;
        end
        if (ack1) begin
            ack_q.push_back(1);
            served1++;
            lat1 = cyc - t0_1;
            req1 = 1'b0;
        end else if (!req1 && served1 < ask1) begin
            req1 = 1'b1;
            t0_1 = cyc;
        end
    end

    // Core model: takes each operand at once, finishes lat cycles later (lat 0 = same cycle).
    int          lat = 2;
    logic        stray_lk = 1'b0, inj_dd = 1'b0;
    int          kcnt = -1, dcnt = -1;
    logic [63:0] ckey = '0;
    logic [31:0] cplain = '0;

    function automatic logic [31:0] fcore(input logic [63:0] k, input logic [31:0] pl);
        if (pl == P0 && k == K0) return C0;
        return pl ^ k[31:0] ^ k[63:32];
    endfunction

    always @(negedge clk) begin
        ldKey = 1'b0; doneKey = 1'b0; ldData = 1'b0; doneData = 1'b0;
        if (R) begin
            kcnt = -1;
            dcnt = -1;
        end else begin
            if (kcnt > 1) kcnt--;
            else if (kcnt == 1) begin doneKey = 1'b1; kcnt = -1; end
            if (dcnt > 1) begin
                dcnt--;
                if (stray_lk) begin ldKey = 1'b1; doneKey = 1'b1; end
            end else if (dcnt == 1) begin
                doneData = 1'b1; cipher = fcore(ckey, cplain); dcnt = -1;
            end
            if (newKey) begin
                ldKey = 1'b1; ckey = key;
                if (lat == 0) doneKey = 1'b1; else kcnt = lat;
            end
            if (newData) begin
                ldData = 1'b1; cplain = plain;
                if (lat == 0) begin doneData = 1'b1; cipher = fcore(ckey, cplain); end
                else dcnt = lat;
            end
            if (inj_dd) begin doneData = 1'b1; cipher = 32'hdeadbeef; end
        end
    end

    task automatic wait_served(input int tgt0, input int tgt1, input int maxc, input string tag);
        int i = 0;
        while ((served0 < tgt0 || served1 < tgt1) && i < maxc) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_served"}, {served0, served1}, {tgt0, tgt1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nk0, nd0, ord;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack0",    64'(ack0),    64'd0);
        chk("rst_ack1",    64'(ack1),    64'd0);
        chk("rst_newKey",  64'(newKey),  64'd0);
        chk("rst_newData", 64'(newData), 64'd0);
        chk("rst_cipher0", 64'(cipher0), 64'd0);
        chk("rst_cipher1", 64'(cipher1), 64'd0);
        chk("rst_key",     key,          64'd0);
        chk("rst_plain",   64'(plain),   64'd0);
        @(posedge clk); #1 R = 1'b0;

        // Single request, cold cache
        key0 = K0; plain0 = P0; ask0 = 1;
        wait_served(1, 0, 40, "t1");
        chk("t1_cipher0", 64'(cipher0), 64'(C0));
        chk("t1_latency", 64'(lat0),    64'd7);
        chk("t1_newKey",  64'(nk),      64'd1);
        chk("t1_newData", 64'(nd),      64'd1);
        chk("t1_acks",    64'(ack_q.size()), 64'd1);
        @(negedge clk);
        chk("t1_ack_pulse", 64'(ack0), 64'd0);
        @(posedge clk); #1;

        // Same request again: key cache hit
        ask0 = 2;
        wait_served(2, 0, 40, "t2");
        chk("t2_cipher0", 64'(cipher0), 64'(C0));
        chk("t2_latency", 64'(lat0),    64'd4);
        chk("t2_newKey",  64'(nk),      64'd1);
        chk("t2_newData", 64'(nd),      64'd2);

        // Zero-latency core: load and done in the same cycle
        lat = 0; key1 = K1; plain1 = P1; ask1 = 1;
        wait_served(2, 1, 40, "t3");
        chk("t3_cipher1", 64'(cipher1), 64'(C1));
        chk("t3_latency", 64'(lat1),    64'd3);
        chk("t3_newKey",  64'(nk),      64'd2);
        chk("t3_cipher0_held", 64'(cipher0), 64'(C0));

        // Simultaneous requests after reset: req0 first
        R = 1'b1;
        @(posedge clk); #1 R = 1'b0;
        @(negedge clk);
        chk("t4_rst_cipher0", 64'(cipher0), 64'd0);
        @(posedge clk); #1;
        lat = 2; ack_q.delete(); nk0 = nk;
        ask0 = 3; ask1 = 2;
        wait_served(3, 2, 80, "t4");
        chk("t4_nacks",   64'(ack_q.size()), 64'd2);
        ord = 0;
        for (int i = 0; i < ack_q.size(); i++) ord = ord * 2 + ack_q[i];
        chk("t4_order",   64'(ord),     64'd1);
        chk("t4_newKey",  64'(nk - nk0), 64'd2);
        chk("t4_cipher0", 64'(cipher0), 64'(C0));
        chk("t4_cipher1", 64'(cipher1), 64'(C1));

        // Both held continuously: strict alternation
        ack_q.delete(); nk0 = nk;
        ask0 = 5; ask1 = 4;
        wait_served(5, 4, 200, "t5");
        chk("t5_nacks",  64'(ack_q.size()), 64'd4);
        ord = 0;
        for (int i = 0; i < ack_q.size(); i++) ord = ord * 2 + ack_q[i];
        chk("t5_order",  64'(ord),      64'd5);
        chk("t5_newKey", 64'(nk - nk0), 64'd4);

        // Reset while the core is busy with data
        lat = 4; ack_q.delete();
        ask0 = 6;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (newData) break;
        end
        chk("t6_reach_data", 64'(newData), 64'd1);
        @(posedge clk); #1 R = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_ack",     64'(ack0 | ack1), 64'd0);
        chk("t6_rst_newData", 64'(newData),     64'd0);
        chk("t6_rst_cipher0", 64'(cipher0),     64'd0);
        chk("t6_rst_cipher1", 64'(cipher1),     64'd0);
        chk("t6_rst_plain",   64'(plain),       64'd0);
        @(posedge clk); #1 R = 1'b0;
        nk0 = nk;
        wait_served(6, 4, 60, "t6");
        chk("t6_nacks",   64'(ack_q.size()), 64'd1);
        chk("t6_reload",  64'(nk - nk0),     64'd1);
        chk("t6_cipher0", 64'(cipher0),      64'(C0));

        // Stray core pulses: doneData in IDLE, ldKey/doneKey during DATA_WAIT
        lat = 3;
        @(posedge clk); #1 inj_dd = 1'b1;
        @(posedge clk); #1 inj_dd = 1'b0;
        @(negedge clk);
        chk("t7_idle_newKey",  64'(newKey),      64'd0);
        chk("t7_idle_newData", 64'(newData),     64'd0);
        chk("t7_idle_ack",     64'(ack0 | ack1), 64'd0);
        chk("t7_idle_cipher0", 64'(cipher0),     64'(C0));
        chk("t7_idle_cipher1", 64'(cipher1),     64'd0);
        @(posedge clk); #1;
        stray_lk = 1'b1; ack_q.delete(); nk0 = nk; nd0 = nd;
        ask0 = 7;
        wait_served(7, 4, 40, "t7");
        stray_lk = 1'b0;
        chk("t7_latency", 64'(lat0),       64'd5);
        chk("t7_newData", 64'(nd - nd0),   64'd1);
        chk("t7_newKey",  64'(nk - nk0),   64'd0);
        chk("t7_cipher0", 64'(cipher0),    64'(C0));
        chk("t7_nacks",   64'(ack_q.size()), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
